// File: rtl/key_command_unit.sv
// key_command_unit
//
// Turns raw USB keyboard keycodes into frame-aligned, rate-limited command levels
// for movement, jump, aim, power and launch. It runs in the clk domain and derives
// one update tick per rising edge of frame_clk. Every command output is a register
// that only changes in the update cycle, so the player stage, which is clocked by
// frame_clk, always samples values that are stable for the whole frame.
//
// Optional feature (compile-time macro LAUNCH_COOLDOWN_EN):
//   defined   - after a launch fires, further launch edges are ignored for COOLDOWN ticks
//   undefined - every new press of S fires a launch
//
// Parameters:
//   REPEAT_DELAY  frames from first fire to first auto-repeat (move/aim/power), 1..255
//   REPEAT_RATE   frames between auto-repeats after the delay, 1..255
//   JUMP_RATE     frames between jump fires while W is held (delay = rate), 1..255
//   COOLDOWN      frames launch stays blocked after a fire (LAUNCH_COOLDOWN_EN), 1..255
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   frame_clk      in   vertical-sync frame clock, asynchronous to clk
//   keycode0..3    in   up to four simultaneous USB keycodes, 0x00 = none
//   frame_tick     out  one-clk pulse in the cycle the command outputs update
//   cmd_left       out  A (0x04)     cmd_right   out  D (0x07)
//   cmd_jump       out  W (0x1A)     cmd_ccw     out  Q (0x14)
//   cmd_cw         out  E (0x08)     cmd_pwr_dn  out  1 (0x1E)
//   cmd_pwr_up     out  3 (0x20)     cmd_launch  out  S (0x16)

module key_command_unit #(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned JUMP_RATE    = 32,
    parameter int unsigned COOLDOWN     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic       frame_tick,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_jump,
    output logic       cmd_ccw,
    output logic       cmd_cw,
    output logic       cmd_pwr_dn,
    output logic       cmd_pwr_up,
    output logic       cmd_launch
);

    // USB HID usage codes of the keys we react to.
    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_JUMP   = 8'h1A;
    localparam logic [7:0] KEY_CCW    = 8'h14;
    localparam logic [7:0] KEY_CW     = 8'h08;
    localparam logic [7:0] KEY_PWR_DN = 8'h1E;
    localparam logic [7:0] KEY_PWR_UP = 8'h20;
    localparam logic [7:0] KEY_LAUNCH = 8'h16;

    // Repeating-action slots; the jump slot uses JUMP_RATE for both gaps.
    localparam int unsigned NUM_REP  = 7;
    localparam int unsigned IDX_LEFT = 0;
    localparam int unsigned IDX_RGHT = 1;
    localparam int unsigned IDX_CCW  = 2;
    localparam int unsigned IDX_CW   = 3;
    localparam int unsigned IDX_DN   = 4;
    localparam int unsigned IDX_UP   = 5;
    localparam int unsigned IDX_JUMP = 6;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_e;

    // A key is held if any keycode slot carries it; 0x00 means an empty slot.
    function automatic logic key_held(input logic [7:0] code,
                                      input logic [7:0] k0,
                                      input logic [7:0] k1,
                                      input logic [7:0] k2,
                                      input logic [7:0] k3);
        return (code != 8'h00) &&
               ((k0 == code) || (k1 == code) || (k2 == code) || (k3 == code));
    endfunction

    // ------------------------------------------------------------------
    // frame_clk synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic fsync1_q, fsync2_q, fsync3_q;
    logic tick;
    logic frame_tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsync1_q     <= 1'b0;
            fsync2_q     <= 1'b0;
            fsync3_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            fsync1_q     <= frame_clk;
            fsync2_q     <= fsync1_q;
            fsync3_q     <= fsync2_q;
            frame_tick_q <= tick;
        end
    end

    // tick is high for one cycle; all command state updates on the edge that ends it,
    // which is also the edge that raises frame_tick.
    assign tick       = fsync2_q & ~fsync3_q;
    assign frame_tick = frame_tick_q;

    // ------------------------------------------------------------------
    // Key decode and conflict resolution
    // ------------------------------------------------------------------
    logic held_left, held_right, held_jump, held_ccw, held_cw;
    logic held_pwr_dn, held_pwr_up, held_launch;
    logic conflict_lr, conflict_rot, conflict_pwr;

    assign held_left   = key_held(KEY_LEFT,   keycode0, keycode1, keycode2, keycode3);
    assign held_right  = key_held(KEY_RIGHT,  keycode0, keycode1, keycode2, keycode3);
    assign held_jump   = key_held(KEY_JUMP,   keycode0, keycode1, keycode2, keycode3);
    assign held_ccw    = key_held(KEY_CCW,    keycode0, keycode1, keycode2, keycode3);
    assign held_cw     = key_held(KEY_CW,     keycode0, keycode1, keycode2, keycode3);
    assign held_pwr_dn = key_held(KEY_PWR_DN, keycode0, keycode1, keycode2, keycode3);
    assign held_pwr_up = key_held(KEY_PWR_UP, keycode0, keycode1, keycode2, keycode3);
    assign held_launch = key_held(KEY_LAUNCH, keycode0, keycode1, keycode2, keycode3);

    assign conflict_lr  = held_left   & held_right;
    assign conflict_rot = held_ccw    & held_cw;
    assign conflict_pwr = held_pwr_dn & held_pwr_up;

    logic [NUM_REP-1:0] rep_held;
    logic [NUM_REP-1:0] rep_force_idle;
    logic [NUM_REP-1:0] rep_cmd;

    always_comb begin
        rep_held                 = '0;
        rep_held[IDX_LEFT]       = held_left;
        rep_held[IDX_RGHT]       = held_right;
        rep_held[IDX_CCW]        = held_ccw;
        rep_held[IDX_CW]         = held_cw;
        rep_held[IDX_DN]         = held_pwr_dn;
        rep_held[IDX_UP]         = held_pwr_up;
        rep_held[IDX_JUMP]       = held_jump;

        // Both members of a conflicting pair are silenced and restarted from idle.
        rep_force_idle           = '0;
        rep_force_idle[IDX_LEFT] = conflict_lr;
        rep_force_idle[IDX_RGHT] = conflict_lr;
        rep_force_idle[IDX_CCW]  = conflict_rot;
        rep_force_idle[IDX_CW]   = conflict_rot;
        rep_force_idle[IDX_DN]   = conflict_pwr;
        rep_force_idle[IDX_UP]   = conflict_pwr;
    end

    // ------------------------------------------------------------------
    // Per-action repeat FSMs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REP; i++) begin : g_rep
        // Gaps are compared as 9-bit values so cnt+1 can never wrap to a false match.
        localparam logic [8:0] FIRST_GAP = (i == IDX_JUMP) ? 9'(JUMP_RATE) : 9'(REPEAT_DELAY);
        localparam logic [8:0] NEXT_GAP  = (i == IDX_JUMP) ? 9'(JUMP_RATE) : 9'(REPEAT_RATE);

        rep_state_e state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       cmd_q, cmd_d;
        logic [8:0] cnt_inc;

        assign cnt_inc = {1'b0, cnt_q} + 9'd1;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= StIdle;
                cnt_q   <= 8'd0;
                cmd_q   <= 1'b0;
            end else if (tick) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                cmd_q   <= cmd_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            cmd_d   = 1'b0;
            if (!rep_held[i] || rep_force_idle[i]) begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end else begin
                case (state_q)
                    StIdle: begin
                        cmd_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StDelay;
                    end
                    StDelay: begin
                        if (cnt_inc == FIRST_GAP) begin
                            cmd_d   = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = StRepeat;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end
                    StRepeat: begin
                        if (cnt_inc == NEXT_GAP) begin
                            cmd_d = 1'b1;
                            cnt_d = 8'd0;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                endcase
            end
        end

        assign rep_cmd[i] = cmd_q;
    end

    assign cmd_left   = rep_cmd[IDX_LEFT];
    assign cmd_right  = rep_cmd[IDX_RGHT];
    assign cmd_ccw    = rep_cmd[IDX_CCW];
    assign cmd_cw     = rep_cmd[IDX_CW];
    assign cmd_pwr_dn = rep_cmd[IDX_DN];
    assign cmd_pwr_up = rep_cmd[IDX_UP];
    assign cmd_jump   = rep_cmd[IDX_JUMP];

    // ------------------------------------------------------------------
    // Launch: edge-triggered on S, sampled once per tick
    // ------------------------------------------------------------------
    logic launch_prev_q;
    logic launch_q;
    logic launch_ready;
    logic launch_fire;

    assign launch_fire = held_launch & ~launch_prev_q & launch_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            launch_prev_q <= 1'b0;
            launch_q      <= 1'b0;
        end else if (tick) begin
            launch_prev_q <= held_launch;
            launch_q      <= launch_fire;
        end
    end

    assign cmd_launch = launch_q;

`ifdef LAUNCH_COOLDOWN_EN
    logic [7:0] cooldown_q, cooldown_d;

    // Edges arriving while the counter is nonzero are dropped, not deferred.
    assign launch_ready = (cooldown_q == 8'd0);

    always_comb begin
        cooldown_d = cooldown_q;
        if (launch_fire) begin
            cooldown_d = 8'(COOLDOWN);
        end else if (cooldown_q != 8'd0) begin
            cooldown_d = cooldown_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cooldown_q <= 8'd0;
        end else if (tick) begin
            cooldown_q <= cooldown_d;
        end
    end
`else
    assign launch_ready = 1'b1;
`endif

endmodule

// File: tb/tb_key_command_unit.sv
// Self-checking bench for key_command_unit: a table of per-tick vectors plus
// hand-written long-hold, conflict, launch, latency and mid-frame reset sequences.

module tb_key_command_unit;

    logic       clk;
    logic       reset;
    logic       frame_clk;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic       frame_tick;
    logic       cmd_left, cmd_right, cmd_jump, cmd_ccw, cmd_cw;
    logic       cmd_pwr_dn, cmd_pwr_up, cmd_launch;

    // Bit order: {launch, pwr_up, pwr_dn, cw, ccw, jump, right, left}
    localparam logic [7:0] O_LEFT  = 8'h01;
    localparam logic [7:0] O_RIGHT = 8'h02;
    localparam logic [7:0] O_JUMP  = 8'h04;
    localparam logic [7:0] O_CCW   = 8'h08;
    localparam logic [7:0] O_CW    = 8'h10;
    localparam logic [7:0] O_DN    = 8'h20;
    localparam logic [7:0] O_UP    = 8'h40;
    localparam logic [7:0] O_LNCH  = 8'h80;

    logic [7:0] outs;
    assign outs = {cmd_launch, cmd_pwr_up, cmd_pwr_dn, cmd_cw, cmd_ccw, cmd_jump,
                   cmd_right, cmd_left};

    key_command_unit #(
        .REPEAT_DELAY(12),
        .REPEAT_RATE (6),
        .JUMP_RATE   (32),
        .COOLDOWN    (60)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_clk (frame_clk),
        .keycode0  (keycode0),
        .keycode1  (keycode1),
        .keycode2  (keycode2),
        .keycode3  (keycode3),
        .frame_tick(frame_tick),
        .cmd_left  (cmd_left),
        .cmd_right (cmd_right),
        .cmd_jump  (cmd_jump),
        .cmd_ccw   (cmd_ccw),
        .cmd_cw    (cmd_cw),
        .cmd_pwr_dn(cmd_pwr_dn),
        .cmd_pwr_up(cmd_pwr_up),
        .cmd_launch(cmd_launch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_exp;

    typedef struct {
        logic [31:0] keys;  // {keycode0, keycode1, keycode2, keycode3}
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_keys(input logic [31:0] k);
        keycode0 = k[31:24];
        keycode1 = k[23:16];
        keycode2 = k[15:8];
        keycode3 = k[7:0];
    endtask

    // One frame: raise frame_clk, confirm nothing moves for two edges, expect the
    // update on the third edge, then lower frame_clk and confirm outputs hold.
    task automatic run_tick(input string nm, input logic [7:0] exp);
        @(negedge clk);
        frame_clk = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s pre%0d outs", nm, e), outs, last_exp);
            check($sformatf("%s pre%0d tick", nm, e), {7'd0, frame_tick}, 8'd0);
        end
        @(posedge clk);
        #1;
        check($sformatf("%s tick", nm), {7'd0, frame_tick}, 8'd1);
        check($sformatf("%s outs", nm), outs, exp);
        @(negedge clk);
        frame_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("%s hold outs", nm), outs, exp);
        check($sformatf("%s hold tick", nm), {7'd0, frame_tick}, 8'd0);
        last_exp = exp;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        last_exp = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [7:0] e;

        // {keys, expected}; each row is one tick, starting right after a reset.
        vecs[0]  = '{32'h00000000, 8'h00};
        vecs[1]  = '{32'h14000000, O_CCW};
        vecs[2]  = '{32'h14080000, 8'h00};           // Q+E conflict
        vecs[3]  = '{32'h00080000, O_CW};            // E restarts fresh
        vecs[4]  = '{32'h00080000, 8'h00};
        vecs[5]  = '{32'h1E000000, O_DN};
        vecs[6]  = '{32'h1E002000, 8'h00};           // 1+3 conflict
        vecs[7]  = '{32'h00002000, O_UP};
        vecs[8]  = '{32'h0007001A, O_RIGHT | O_JUMP};
        vecs[9]  = '{32'h0007001A, 8'h00};
        vecs[10] = '{32'h16000000, O_LNCH};
        vecs[11] = '{32'h16160000, 8'h00};           // still held: no new edge
        vecs[12] = '{32'h00000000, 8'h00};
`ifdef LAUNCH_COOLDOWN_EN
        vecs[13] = '{32'h00000016, 8'h00};           // inside cooldown
`else
        vecs[13] = '{32'h00000016, O_LNCH};
`endif
        vecs[14] = '{32'h04071408, 8'h00};           // two conflicts at once
        vecs[15] = '{32'h04000000, O_LEFT};

        reset     = 1'b0;
        frame_clk = 1'b0;
        set_keys(32'h0);
        last_exp  = 8'h00;
        #12;
        check("reset outs", outs, 8'h00);
        check("reset tick", {7'd0, frame_tick}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            set_keys(vecs[i].keys);
            run_tick($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hold A on keycode0: fires at 0, 12, 18, 24, 30
        apply_reset();
        set_keys(32'h04000000);
        for (int t = 0; t < 36; t++) begin
            e = (t == 0 || t == 12 || t == 18 || t == 24 || t == 30) ? O_LEFT : 8'h00;
            run_tick($sformatf("left t%0d", t), e);
        end
        set_keys(32'h0);
        run_tick("left release", 8'h00);

        // A on keycode1 with D on keycode3: silent; dropping D gives an immediate left
        apply_reset();
        set_keys(32'h00040007);
        for (int t = 0; t < 40; t++) run_tick($sformatf("conflict t%0d", t), 8'h00);
        set_keys(32'h00040000);
        run_tick("conflict release", O_LEFT);

        // Hold W for 70 ticks: fires at 0, 32, 64
        apply_reset();
        set_keys(32'h1A000000);
        for (int t = 0; t < 70; t++) begin
            e = (t == 0 || t == 32 || t == 64) ? O_JUMP : 8'h00;
            run_tick($sformatf("jump t%0d", t), e);
        end

        // S for 5 ticks, released 2, pressed again
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            set_keys((t == 5 || t == 6) ? 32'h0 : 32'h00160000);
`ifdef LAUNCH_COOLDOWN_EN
            e = (t == 0) ? O_LNCH : 8'h00;
`else
            e = (t == 0 || t == 7) ? O_LNCH : 8'h00;
`endif
            run_tick($sformatf("launch t%0d", t), e);
        end

        // Hold E into REPEAT, then reset mid-frame
        apply_reset();
        set_keys(32'h00000008);
        for (int t = 0; t <= 12; t++) begin
            e = (t == 0 || t == 12) ? O_CW : 8'h00;
            run_tick($sformatf("cw t%0d", t), e);
        end
        @(negedge clk);
        frame_clk = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async reset outs", outs, 8'h00);
        check("async reset tick", {7'd0, frame_tick}, 8'd0);
        @(negedge clk);
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset held outs", outs, 8'h00);
        @(negedge clk);
        reset    = 1'b1;
        last_exp = 8'h00;
        repeat (2) @(posedge clk);
        run_tick("cw after reset", O_CW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
